// File: rtl/wb_bank_fabric_if.sv
// ----------------------------------------------------------------------------
// wb_bank_fabric_if
//   Signal bundle between the cpu, the bank fabric and its NSLAVES slaves.
//   master modport : the environment's view (cpu request side + slave replies)
//   slave modport  : the fabric's view (takes cpu requests, drives slaves)
//
//   m_adr_i/m_dat_i/m_sel_i/m_we_i/m_stb_i : cpu request
//   m_ack_o/m_err_o/m_dat_o                : cpu response
//   s_adr_o/s_dat_o/s_sel_o/s_we_o         : registered request, shared by slaves
//   s_stb_o                                : one-hot slave strobe
//   s_ack_i/s_dat_i                        : per-slave ack and read data
//   err_adr_o                              : address of last errored transfer
// ----------------------------------------------------------------------------
interface wb_bank_fabric_if #(
    parameter int NSLAVES = 4,
    parameter int DW      = 32
);
    logic [31:0]         m_adr_i;
    logic [DW-1:0]       m_dat_i;
    logic [DW/8-1:0]     m_sel_i;
    logic                m_we_i;
    logic                m_stb_i;
    logic                m_ack_o;
    logic                m_err_o;
    logic [DW-1:0]       m_dat_o;
    logic [31:0]         s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW/8-1:0]     s_sel_o;
    logic                s_we_o;
    logic [NSLAVES-1:0]  s_stb_o;
    logic [NSLAVES-1:0]  s_ack_i;
    logic [NSLAVES*DW-1:0] s_dat_i;
    logic [31:0]         err_adr_o;

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_adr_o, s_dat_o, s_sel_o, s_we_o,
               s_stb_o, err_adr_o
    );

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_adr_o, s_dat_o, s_sel_o, s_we_o,
               s_stb_o, err_adr_o
    );
endinterface

// File: rtl/wb_bank_fabric.sv
// ----------------------------------------------------------------------------
// wb_bank_fabric
//   Single-master bus fabric. Decodes bank = adr[31:24] against BANK_BASE,
//   registers the request, strobes exactly one slave and returns its ack/data
//   to the cpu. Unmapped banks and slaves that do not ack within TIMEOUT
//   strobe cycles are answered with an error pulse.
//
//   clk   : system clock
//   rst_i : asynchronous reset, active-high
//   bus   : wb_bank_fabric_if.slave (cpu request/response, slave strobes,
//           per-slave ack/data, err_adr_o)
// ----------------------------------------------------------------------------
module wb_bank_fabric #(
    parameter int                   NSLAVES   = 4,
    parameter logic [NSLAVES*8-1:0] BANK_BASE = {8'h03, 8'h02, 8'h01, 8'h00},
    parameter int                   TIMEOUT   = 15,
    parameter int                   DW        = 32
) (
    input  logic            clk,
    input  logic            rst_i,
    wb_bank_fabric_if.slave bus
);

    localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last strobe cycle a slave is allowed
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;
    logic              r_err;
    logic [31:0]       r_adr;
    logic [DW-1:0]     r_wdat;
    logic [DW/8-1:0]   r_sel;
    logic              r_we;
    logic [DW-1:0]     r_mdat;
    logic [31:0]       r_erradr;

    logic              w_hit;
    logic [IW-1:0]     w_hit_idx;
    logic              w_sel_ack;
    logic [DW-1:0]     w_sel_dat;
    logic [NSLAVES-1:0] w_stb;
    logic              w_start;
    logic              w_unmapped;
    logic              w_ack_done;
    logic              w_tmo;

    // Bank decode; scanning downwards lets the lowest matching index win
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (BANK_BASE[i*8 +: 8] == bus.m_adr_i[31:24]) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
        end
    end

    // Selected-slave mux; acks from other slaves never reach the FSM
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        w_stb     = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_ack = bus.s_ack_i[i];
                w_sel_dat = bus.s_dat_i[i*DW +: DW];
                w_stb[i]  = (r_state == ST_ACTIVE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_unmapped = 1'b0;
        w_ack_done = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.m_stb_i) begin
                    if (w_hit) begin
                        w_start = 1'b1;
                        w_next  = ST_ACTIVE;
                    end else begin
                        w_unmapped = 1'b1;
                        w_next     = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                // Ack is checked first so an ack in the last allowed cycle wins
                if (w_sel_ack) begin
                    w_ack_done = 1'b1;
                    w_next     = ST_RESP;
                end else if ((TIMEOUT > 0) && (r_cnt == CNT_LAST)) begin
                    w_tmo  = 1'b1;
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_adr    <= '0;
            r_wdat   <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_mdat   <= '0;
            r_erradr <= '0;
        end else begin
            // Request is captured only in IDLE; later m_* changes are ignored
            if (w_start || w_unmapped) begin
                r_adr  <= bus.m_adr_i;
                r_wdat <= bus.m_dat_i;
                r_sel  <= bus.m_sel_i;
                r_we   <= bus.m_we_i;
            end

            if (w_start) begin
                r_idx <= w_hit_idx;
                r_cnt <= '0;
            end else if ((r_state == ST_ACTIVE) && (TIMEOUT > 0)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_unmapped) begin
                r_err    <= 1'b1;
                r_mdat   <= '0;
                r_erradr <= bus.m_adr_i;
            end else if (w_tmo) begin
                r_err    <= 1'b1;
                r_mdat   <= '0;
                r_erradr <= r_adr;
            end else if (w_ack_done) begin
                r_err <= 1'b0;
                // Writes leave the last read data in place
                if (!r_we) begin
                    r_mdat <= w_sel_dat;
                end
            end
        end
    end

    // Response pulses are decoded from state so reset clears them immediately
    assign bus.m_ack_o   = (r_state == ST_RESP) && !r_err;
    assign bus.m_err_o   = (r_state == ST_RESP) && r_err;
    assign bus.m_dat_o   = r_mdat;
    assign bus.s_adr_o   = r_adr;
    assign bus.s_dat_o   = r_wdat;
    assign bus.s_sel_o   = r_sel;
    assign bus.s_we_o    = r_we;
    assign bus.s_stb_o   = w_stb;
    assign bus.err_adr_o = r_erradr;

endmodule

// File: tb/tb_wb_bank_fabric.sv
module tb_wb_bank_fabric;

    localparam int TMO = 4;
    localparam int NEVER = 255;
    // Bank served by each slave; slave3 duplicates bank 01 so slave1 must win
    localparam logic [7:0] BANKS [4] = '{8'h00, 8'h01, 8'h02, 8'h01};

    typedef struct {
        logic        err;
        logic [31:0] dat;
        logic [31:0] eadr;
        int          lat;
        int          stbc;
        logic [3:0]  onehot;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        we;
        int          issue;
    } exp_t;

    logic clk;
    logic rst_i;

    wb_bank_fabric_if #(.NSLAVES(4), .DW(32)) bus ();

    wb_bank_fabric #(
        .NSLAVES  (4),
        .BANK_BASE({8'h01, 8'h02, 8'h01, 8'h00}),
        .TIMEOUT  (TMO),
        .DW       (32)
    ) dut (
        .clk  (clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sbq[$];
    logic [31:0] s_data[4];
    int          wait_cfg[4];
    logic [3:0]  spur_cfg;
    bit          mon_en;
    int          stbc_seen;
    logic [31:0] last_dat;
    logic [31:0] last_eadr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int decode(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            if (BANKS[i] == b) return i;
        end
        return -1;
    endfunction

    // Slave models: ack in stb cycle wait_cfg+1, plus optional spurious acks
    initial begin
        int         stbcnt[4];
        logic [3:0] ack;
        for (int i = 0; i < 4; i++) stbcnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (bus.s_stb_o[i]) stbcnt[i]++;
                else stbcnt[i] = 0;
                ack[i] = (bus.s_stb_o[i] && (stbcnt[i] == wait_cfg[i] + 1)) || spur_cfg[i];
            end
            bus.s_ack_i = ack;
        end
    end

    // Monitor: checks strobe content and pops the scoreboard on every response
    initial begin
        exp_t e;
        bit   prev_resp;
        prev_resp = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_resp) check("pulse_width", {bus.m_ack_o, bus.m_err_o}, 2'b00);
                prev_resp = 0;
                if (bus.s_stb_o != 4'b0000) begin
                    if (sbq.size() == 0) begin
                        check("stray_stb", bus.s_stb_o, 4'b0000);
                    end else begin
                        e = sbq[0];
                        check("stb_bus", {bus.s_stb_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o},
                              {e.onehot, e.adr, e.wdat, e.sel, e.we});
                        stbc_seen++;
                    end
                end
                if (bus.m_ack_o || bus.m_err_o) begin
                    if (sbq.size() == 0) begin
                        check("stray_resp", {bus.m_ack_o, bus.m_err_o}, 2'b00);
                    end else begin
                        e = sbq.pop_front();
                        check("resp_kind", {bus.m_ack_o, bus.m_err_o}, {~e.err, e.err});
                        check("m_dat", bus.m_dat_o, e.dat);
                        check("err_adr", bus.err_adr_o, e.eadr);
                        check("latency", cyc - e.issue, e.lat);
                        check("stb_cycles", stbc_seen, e.stbc);
                        stbc_seen = 0;
                        prev_resp = 1;
                    end
                end
            end
        end
    end

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wdat, input int wt, input logic [3:0] spur,
                        input logic [31:0] tdat, input bit scramble);
        exp_t e;
        int   idx;
        int   n;
        idx = decode(adr[31:24]);
        for (int i = 0; i < 4; i++) begin
            s_data[i]   = $urandom;
            wait_cfg[i] = NEVER;
        end
        if (idx >= 0) begin
            s_data[idx]   = tdat;
            wait_cfg[idx] = wt;
            spur_cfg      = spur & ~(4'b0001 << idx);
        end else begin
            spur_cfg = spur;
        end
        bus.s_dat_i = {s_data[3], s_data[2], s_data[1], s_data[0]};

        e.adr  = adr;
        e.wdat = wdat;
        e.sel  = sel;
        e.we   = we;
        if (idx < 0) begin
            e.err = 1; e.lat = 1; e.stbc = 0; e.onehot = 4'b0000;
            last_dat = 32'h0; last_eadr = adr;
        end else if (wt < TMO) begin
            e.err = 0; e.lat = wt + 2; e.stbc = wt + 1; e.onehot = 4'b0001 << idx;
            if (!we) last_dat = tdat;
        end else begin
            e.err = 1; e.lat = TMO + 1; e.stbc = TMO; e.onehot = 4'b0001 << idx;
            last_dat = 32'h0; last_eadr = adr;
        end
        e.dat  = last_dat;
        e.eadr = last_eadr;

        bus.m_adr_i = adr;
        bus.m_we_i  = we;
        bus.m_sel_i = sel;
        bus.m_dat_i = wdat;
        bus.m_stb_i = 1'b1;
        e.issue = cyc;
        sbq.push_back(e);

        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (scramble && n == 1) begin
                bus.m_adr_i = $urandom;
                bus.m_dat_i = $urandom;
                bus.m_we_i  = ~we;
                bus.m_sel_i = ~sel;
            end
        end while (!(bus.m_ack_o || bus.m_err_o) && n < 50);
        if (n >= 50) check("resp_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #2;
        bus.m_stb_i = 1'b0;
        spur_cfg    = 4'b0000;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;
        rst_i       = 1'b1;
        mon_en      = 0;
        stbc_seen   = 0;
        last_dat    = 32'h0;
        last_eadr   = 32'h0;
        spur_cfg    = 4'b0000;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.s_ack_i = '0;
        bus.s_dat_i = '0;
        for (int i = 0; i < 4; i++) wait_cfg[i] = NEVER;

        repeat (3) @(posedge clk);
        #2;
        check("reset_state", {bus.m_ack_o, bus.m_err_o, bus.s_stb_o, bus.m_dat_o, bus.s_adr_o,
                              bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.err_adr_o}, '0);
        rst_i = 1'b0;
        @(posedge clk);
        #2;
        mon_en = 1;

        // Directed cases
        xfer(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 4'b0000, 32'hCAFE_0001, 0);
        xfer(32'h0100_0000, 1'b1, 4'b0001, 32'h0000_005A, 0, 4'b0000, 32'hDEAD_BEEF, 0);
        xfer(32'h7F00_0000, 1'b0, 4'hF, 32'h0, 0, 4'b0000, 32'h0, 0);
        xfer(32'h0200_0123, 1'b0, 4'hF, 32'h0, NEVER, 4'b0000, 32'h0, 0);
        xfer(32'h0200_0040, 1'b0, 4'hF, 32'h0, TMO - 1, 4'b0010, 32'h1234_5678, 0);
        xfer(32'h0100_0008, 1'b0, 4'hF, 32'h0, 2, 4'b1000, 32'h0BAD_F00D, 1);

        // Reset while a slave is being strobed
        mon_en = 0;
        for (int i = 0; i < 4; i++) wait_cfg[i] = NEVER;
        bus.m_adr_i = 32'h0200_0004;
        bus.m_we_i  = 1'b0;
        bus.m_stb_i = 1'b1;
        @(posedge clk);
        #2;
        check("pre_reset_stb", bus.s_stb_o, 4'b0100);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("async_reset", {bus.m_ack_o, bus.m_err_o, bus.s_stb_o, bus.m_dat_o, bus.s_adr_o,
                              bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.err_adr_o}, '0);
        bus.m_stb_i = 1'b0;
        @(posedge clk);
        #2;
        check("reset_no_resp", {bus.m_ack_o, bus.m_err_o}, 2'b00);
        rst_i     = 1'b0;
        last_dat  = 32'h0;
        last_eadr = 32'h0;
        stbc_seen = 0;
        @(posedge clk);
        #2;
        mon_en = 1;
        xfer(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 4'b0000, 32'hCAFE_0002, 0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1, 2: b = 8'(r);
                3:       b = 8'h03;
                default: b = 8'h10 + 8'($urandom_range(0, 200));
            endcase
            xfer({b, 24'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
                 ($urandom_range(0, 6) == 6) ? NEVER : $urandom_range(0, 5),
                 4'($urandom), $urandom, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2;
            end
        end

        repeat (4) @(posedge clk);
        #2;
        check("queue_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
